// File: rtl/clahe_tile_locator.sv
// CLAHE tile locator: delays the pixel stream by one clock and tags each
// pixel with its tile index, tracking frame geometry and bank selection.
module clahe_tile_locator #(
    parameter int IMG_W   = 1280,
    parameter int IMG_H   = 720,
    parameter int TILES_X = 8,
    parameter int TILES_Y = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_y,
    input  logic       in_href,
    input  logic       in_vsync,
    output logic [7:0] out_y,
    output logic       out_href,
    output logic       out_vsync,
    output logic [5:0] tile_idx,
    output logic       ping_pong_flag,
    output logic       frame_done,
    output logic       geom_err
);

    localparam int PX_T = IMG_W / TILES_X;
    localparam int LN_T = IMG_H / TILES_Y;
    localparam int PXW  = (PX_T > 1) ? $clog2(PX_T) : 1;
    localparam int LNW  = (LN_T > 1) ? $clog2(LN_T) : 1;
    localparam int CW   = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int RW   = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
    localparam int LPW  = $clog2(IMG_W + 2);
    localparam int LCW  = $clog2(IMG_H + 2);

    localparam logic [PXW-1:0] PX_MAX  = PXW'(PX_T - 1);
    localparam logic [LNW-1:0] LN_MAX  = LNW'(LN_T - 1);
    localparam logic [CW-1:0]  COL_MAX = CW'(TILES_X - 1);
    localparam logic [RW-1:0]  ROW_MAX = RW'(TILES_Y - 1);
    localparam logic [LPW-1:0] LPX_SAT = LPW'(IMG_W + 1);
    localparam logic [LCW-1:0] LNS_SAT = LCW'(IMG_H + 1);

    logic [7:0]     r_y;
    logic           r_href_d;
    logic           r_vsync_d;
    logic [5:0]     r_tile;
    logic           r_pp;
    logic           r_done;
    logic           r_err;
    logic           r_seen;
    logic [PXW-1:0] r_px;
    logic [CW-1:0]  r_col;
    logic [LNW-1:0] r_ln;
    logic [RW-1:0]  r_row;
    logic [LPW-1:0] r_lpx;
    logic [LCW-1:0] r_lines;

    logic           w_vs_rise;
    logic           w_pix;
    logic           w_line_end;
    logic [5:0]     w_idx;

    assign w_vs_rise  = in_vsync & ~r_vsync_d;
    assign w_pix      = in_href & ~in_vsync;
    // A falling href only closes a line that actually delivered pixels;
    // anything seen during vsync is blanking and never counted.
    assign w_line_end = ~in_href & r_href_d & ~in_vsync & (r_lpx != '0);
    assign w_idx      = 6'(r_row) * 6'(TILES_X) + 6'(r_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_href_d  <= 1'b0;
            r_vsync_d <= 1'b0;
            r_tile    <= '0;
            r_pp      <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_seen    <= 1'b0;
            r_px      <= '0;
            r_col     <= '0;
            r_ln      <= '0;
            r_row     <= '0;
            r_lpx     <= '0;
            r_lines   <= '0;
        end else begin
            r_y       <= in_y;
            r_href_d  <= in_href;
            r_vsync_d <= in_vsync;
            r_tile    <= w_pix ? w_idx : 6'd0;
            r_done    <= 1'b0;
            if (w_vs_rise) begin
                r_px    <= '0;
                r_col   <= '0;
                r_ln    <= '0;
                r_row   <= '0;
                r_lpx   <= '0;
                r_lines <= '0;
                r_pp    <= ~r_pp;
                r_seen  <= 1'b1;
                if (r_seen) begin
                    if (r_lines == LCW'(IMG_H))
                        r_done <= 1'b1;
                    else
                        r_err <= 1'b1;
                end
            end else if (w_pix) begin
                if (r_lpx != LPX_SAT)
                    r_lpx <= r_lpx + LPW'(1);
                if (r_px != PX_MAX) begin
                    r_px <= r_px + PXW'(1);
                end else if (r_col != COL_MAX) begin
                    r_px  <= '0;
                    r_col <= r_col + CW'(1);
                end
            end else if (w_line_end) begin
                r_px  <= '0;
                r_col <= '0;
                r_lpx <= '0;
                if (r_lines != LNS_SAT)
                    r_lines <= r_lines + LCW'(1);
                if (r_lpx != LPW'(IMG_W))
                    r_err <= 1'b1;
                if (r_ln != LN_MAX) begin
                    r_ln <= r_ln + LNW'(1);
                end else begin
                    r_ln <= '0;
                    if (r_row != ROW_MAX)
                        r_row <= r_row + RW'(1);
                end
            end
        end
    end

    assign out_y          = r_y;
    assign out_href       = r_href_d;
    assign out_vsync      = r_vsync_d;
    assign tile_idx       = r_tile;
    assign ping_pong_flag = r_pp;
    assign frame_done     = r_done;
    assign geom_err       = r_err;

endmodule

// File: tb/tb_clahe_tile_locator.sv
// Bench for clahe_tile_locator: random luma against a coordinate-based
// reference model, plus directed frame-geometry scenarios.
module tb_clahe_tile_locator;

    localparam int W   = 32;
    localparam int H   = 16;
    localparam int TX  = 8;
    localparam int TY  = 8;
    localparam int PXT = W / TX;
    localparam int LNT = H / TY;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_y = 8'd0;
    logic       in_href = 1'b0;
    logic       in_vsync = 1'b0;
    logic [7:0] out_y;
    logic       out_href;
    logic       out_vsync;
    logic [5:0] tile_idx;
    logic       ping_pong_flag;
    logic       frame_done;
    logic       geom_err;

    clahe_tile_locator #(
        .IMG_W(W), .IMG_H(H), .TILES_X(TX), .TILES_Y(TY)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_y(in_y),
        .in_href(in_href),
        .in_vsync(in_vsync),
        .out_y(out_y),
        .out_href(out_href),
        .out_vsync(out_vsync),
        .tile_idx(tile_idx),
        .ping_pong_flag(ping_pong_flag),
        .frame_done(frame_done),
        .geom_err(geom_err)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // reference model: pixel position within the line, line within the frame
    int m_x, m_y, m_lines;
    bit m_pvs, m_phr, m_pp, m_err, m_seen;
    int done_cnt;

    logic [5:0] obs_tile [16][40];
    logic [7:0] obs_y    [16][40];
    logic [5:0] map0     [16][40];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int tile_of(input int x, input int y);
        int r, c;
        r = y / LNT;
        c = x / PXT;
        if (r > TY - 1) r = TY - 1;
        if (c > TX - 1) c = TX - 1;
        return r * TX + c;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_lines = 0;
        m_pvs = 0; m_phr = 0; m_pp = 0; m_err = 0; m_seen = 0;
    endtask

    task automatic tick();
        int cx, cy;
        logic [5:0] et;
        logic [7:0] ey;
        bit eh, ev, ed;
        ey = in_y; eh = in_href; ev = in_vsync;
        cx = m_x; cy = m_y; ed = 0;
        et = (eh && !ev) ? 6'(tile_of(cx, cy)) : 6'd0;
        if (ev && !m_pvs) begin
            if (m_seen) begin
                if (m_lines == H) ed = 1;
                else m_err = 1;
            end
            m_seen = 1; m_pp = ~m_pp;
            m_x = 0; m_y = 0; m_lines = 0;
        end else if (eh && !ev) begin
            m_x++;
        end else if (!eh && m_phr && !ev && m_x > 0) begin
            if (m_x != W) m_err = 1;
            m_lines++; m_y++; m_x = 0;
        end
        m_pvs = ev; m_phr = eh;
        @(posedge clk);
        #1;
        chk("out_y", out_y, ey);
        chk("out_href", out_href, eh);
        chk("out_vsync", out_vsync, ev);
        chk("tile_idx", tile_idx, et);
        chk("frame_done", frame_done, ed);
        chk("ping_pong", ping_pong_flag, m_pp);
        chk("geom_err", geom_err, m_err);
        if (frame_done === 1'b1) done_cnt++;
        if (eh && !ev && cy < 16 && cx < 40) begin
            obs_tile[cy][cx] = tile_idx;
            obs_y[cy][cx]    = out_y;
        end
    endtask

    task automatic line(input int len, input int fy);
        for (int i = 0; i < len; i++) begin
            in_href = 1'b1;
            in_y = (i == 0 && fy >= 0) ? 8'(fy) : 8'($urandom);
            tick();
        end
        in_href = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
    endtask

    task automatic vsync_pulse();
        in_vsync = 1'b1;
        repeat (2) tick();
        in_vsync = 1'b0;
        repeat (2) tick();
    endtask

    task automatic full_frame(input int fy);
        for (int l = 0; l < H; l++) line(W, (l == 0) ? fy : -1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_y"}, out_y, 8'd0);
        chk({tag, "_href"}, out_href, 1'b0);
        chk({tag, "_vs"}, out_vsync, 1'b0);
        chk({tag, "_tile"}, tile_idx, 6'd0);
        chk({tag, "_pp"}, ping_pong_flag, 1'b0);
        chk({tag, "_done"}, frame_done, 1'b0);
        chk({tag, "_err"}, geom_err, 1'b0);
    endtask

    initial begin
        int diffs;
        model_reset();
        done_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        rst_n = 1'b1;

        // first frame after reset: no frame_done, bank flips to 1
        vsync_pulse();
        chk("vsA_done", done_cnt, 0);
        chk("vsA_pp", ping_pong_flag, 1'b1);
        full_frame(8'hA5);
        chk("lat_y", obs_y[0][0], 8'hA5);
        chk("map_0_0", obs_tile[0][0], 6'd0);
        chk("map_0_3", obs_tile[0][3], 6'd0);
        chk("map_0_4", obs_tile[0][4], 6'd1);
        chk("map_0_7", obs_tile[0][7], 6'd1);
        chk("map_0_28", obs_tile[0][28], 6'd7);
        chk("map_0_31", obs_tile[0][31], 6'd7);
        chk("map_2_0", obs_tile[2][0], 6'd8);
        chk("map_15_31", obs_tile[15][31], 6'd63);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 40; c++) map0[r][c] = obs_tile[r][c];
        vsync_pulse();
        chk("vsB_done", done_cnt, 1);
        chk("vsB_pp", ping_pong_flag, 1'b0);
        chk("vsB_err", geom_err, 1'b0);

        // long first line, then a 15-line frame
        line(36, -1);
        for (int c = 32; c < 36; c++) chk("long_tile", obs_tile[0][c], 6'd7);
        chk("long_err", geom_err, 1'b1);
        for (int l = 0; l < 14; l++) line(W, -1);
        vsync_pulse();
        chk("short_done", done_cnt, 1);
        chk("short_pp", ping_pong_flag, 1'b1);
        chk("short_err", geom_err, 1'b1);

        // reset in the middle of line 7
        for (int l = 0; l < 7; l++) line(W, -1);
        in_href = 1'b1;
        repeat (10) begin
            in_y = 8'($urandom);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check_zero("midrst");
        in_href = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("midrst_hold");
        rst_n = 1'b1;
        model_reset();
        done_cnt = 0;
        vsync_pulse();
        chk("vsD_done", done_cnt, 0);
        chk("vsD_err", geom_err, 1'b0);
        full_frame(-1);
        chk("rst_map_0_0", obs_tile[0][0], 6'd0);
        vsync_pulse();
        chk("vsE_done", done_cnt, 1);
        chk("vsE_err", geom_err, 1'b0);
        chk("vsE_pp", ping_pong_flag, 1'b0);

        // href falling on the same clock as vsync rising
        for (int l = 0; l < 5; l++) line(W, -1);
        in_href = 1'b1;
        for (int i = 0; i < W; i++) begin
            in_y = 8'($urandom);
            tick();
        end
        in_href = 1'b0;
        in_vsync = 1'b1;
        repeat (2) tick();
        in_vsync = 1'b0;
        repeat (2) tick();
        chk("coin_pp", ping_pong_flag, 1'b1);
        chk("coin_err", geom_err, 1'b1);
        chk("coin_done", done_cnt, 1);
        full_frame(-1);
        diffs = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 32; c++)
                if (obs_tile[r][c] !== map0[r][c]) diffs++;
        chk("coin_map", diffs, 0);
        vsync_pulse();
        chk("vsG_done", done_cnt, 2);
        chk("vsG_pp", ping_pong_flag, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
